// File: rtl/multi_clock_divider.sv
// multi_clock_divider: N-channel programmable clock/tone divider.
// Square or single-pulse output per channel, updates applied at period boundaries.
module multi_clock_divider #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 17,
    parameter int DEFAULT_DIV = 113636
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS-1:0]       mode_in,
    input  logic [CHANNELS*WIDTH-1:0] divisor,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       rise_tick,
    output logic [CHANNELS-1:0]       pending
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0]    cnt      [CHANNELS];
    logic [WIDTH-1:0]    cur_div  [CHANNELS];
    logic [WIDTH-1:0]    pend_div [CHANNELS];
    logic [WIDTH-1:0]    div_in   [CHANNELS];
    logic [CHANNELS-1:0] cur_mode;
    logic [CHANNELS-1:0] pend_mode;
    logic [CHANNELS-1:0] run;
    logic [CHANNELS-1:0] term;

    // Per-channel divisor slice, run qualifier and terminal-edge detect
    always_comb begin
        run  = '0;
        term = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            div_in[i] = divisor[i*WIDTH +: WIDTH];
            run[i]    = enable[i] && (cur_div[i] != '0);
            term[i]   = run[i] && (cnt[i] == cur_div[i] - ONE);
        end
    end

    // Counters, outputs and pending/apply handling for every channel
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]      <= '0;
                cur_div[i]  <= DEF_DIV;
                pend_div[i] <= '0;
            end
            cur_mode  <= '0;
            pend_mode <= '0;
            pending   <= '0;
            clk_out   <= '0;
            rise_tick <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (term[i]) begin
                    cnt[i] <= '0;
                    // The edge that ends a period is shaped by the outgoing mode
                    if (cur_mode[i]) begin
                        clk_out[i]   <= 1'b1;
                        rise_tick[i] <= 1'b1;
                    end else begin
                        clk_out[i]   <= ~clk_out[i];
                        rise_tick[i] <= ~clk_out[i];
                    end
                    // A load on the boundary itself bypasses the pending slot
                    if (load[i]) begin
                        cur_div[i]  <= div_in[i];
                        cur_mode[i] <= mode_in[i];
                        pending[i]  <= 1'b0;
                    end else if (pending[i]) begin
                        cur_div[i]  <= pend_div[i];
                        cur_mode[i] <= pend_mode[i];
                        pending[i]  <= 1'b0;
                    end
                end else begin
                    rise_tick[i] <= 1'b0;
                    if (run[i]) begin
                        cnt[i] <= cnt[i] + ONE;
                        if (cur_mode[i]) begin
                            clk_out[i] <= 1'b0;
                        end
                    end else begin
                        cnt[i]     <= '0;
                        clk_out[i] <= 1'b0;
                    end
                    // Disabled or idle channels have no boundary to wait for
                    if (!run[i] && pending[i]) begin
                        cur_div[i]  <= pend_div[i];
                        cur_mode[i] <= pend_mode[i];
                        pending[i]  <= 1'b0;
                    end
                    // Capture after the apply so a fresh load stays pending
                    if (load[i]) begin
                        pend_div[i]  <= div_in[i];
                        pend_mode[i] <= mode_in[i];
                        pending[i]   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- N-channel programmable clock/tone divider.
- Each channel divides the system clock by a runtime-loadable divisor in either square-wave mode or single-pulse mode.
- Divisor and mode updates are glitch-free: they take effect only at a period boundary.
- Sits between control logic (e.g. note selection) and audio/LED/timing consumers; a generalised successor to the single fixed-divisor divider.

Parameters:
- CHANNELS, 4, number of independent divider channels.
- WIDTH, 17, divisor/counter width in bits.
- DEFAULT_DIV, 113636, divisor loaded into every channel at reset; must fit in WIDTH bits.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  CHANNELS  per-channel run enable.
- load  in  CHANNELS  per-channel one-cycle strobe; captures divisor and mode_in for that channel.
- mode_in  in  CHANNELS  0 = square (toggle), 1 = pulse; captured on load.
- divisor  in  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- clk_out  out  CHANNELS  divided output, registered.
- rise_tick  out  CHANNELS  one-cycle pulse on each 0->1 transition of clk_out, registered, coincident with clk_out going high.
- pending  out  CHANNELS  high while a loaded divisor/mode is waiting for a boundary.

Behaviour:

Per-channel state:
- cnt[WIDTH], cur_div, cur_mode, pend_div, pend_mode, pend_valid.

Reset (reset low, asynchronous):
- cnt=0, cur_div=DEFAULT_DIV, cur_mode=square.
- pend_valid=0; clk_out, rise_tick and pending all 0.

Counting (enable=1, cur_div!=0):
- cnt steps 0..cur_div-1.
- Terminal edge is the edge where cnt==cur_div-1; cnt wraps to 0 there.

Square mode:
- clk_out toggles on every terminal edge.
- Output period is 2*cur_div clocks at 50% duty.
- rise_tick=1 for the one cycle in which clk_out becomes 1.

Pulse mode:
- clk_out=1 for exactly the cycle following each terminal edge, 0 otherwise.
- rise_tick equals clk_out.
- Output period is cur_div clocks.

cur_div=1:
- Square: clk_out toggles every cycle (clock/2).
- Pulse: clk_out and rise_tick stay high continuously.

cur_div=0:
- Channel idle: cnt held at 0, clk_out=0, rise_tick=0.

Load:
- load[i]=1 captures pend_div/pend_mode and sets pend_valid.
- A later load before the boundary overwrites the pending value; last load wins.

Apply rule:
- Pending values move into cur_div/cur_mode and pend_valid clears:
  - on the next terminal edge, or
  - on the next edge if the channel is disabled or idle (cur_div==0).
- If load coincides with a terminal edge, the newly loaded value is applied at that same edge (bypass); pending stays 0.
- After an apply, cnt restarts at 0 and the new period starts immediately.
- In square mode clk_out keeps its current level across the apply; the next toggle comes after new cur_div cycles.

Disable (enable=0):
- At the next edge: cnt=0, clk_out=0, rise_tick=0.
- cur_div and cur_mode are retained.

Re-enable:
- The first terminal edge occurs cur_div edges after the first edge with enable=1.
- In square mode the first transition is therefore a rise (rise_tick=1).

Reset mid-operation:
- Outputs go to 0 immediately (asynchronous).
- Any pending load is discarded and cur_div returns to DEFAULT_DIV.

Channel independence:
- Channels are fully independent; simultaneous events on different channels do not interact.

Latency:
- clk_out and rise_tick are registered, with no combinational path from any input.

Test Plan:
1. Reset then ch0 load div=3 mode=0 while disabled, then enable=1 -> clk_out[0] high after edge 3, toggles every 3 edges (period 6); rise_tick[0] pulses every 6 clocks; pending[0] clears one edge after load.
2. Ch1 running div=4 square; load div=2 at cnt=1 -> pending[1]=1 until the terminal edge 2 edges later; thereafter clk_out[1] toggles every 2 clocks with no pulse shorter than 2 clocks.
3. Ch2 load div=5 mode=1, enable -> clk_out[2]=rise_tick[2]=1 for one cycle every 5 clocks; div=1 in pulse mode -> constant 1; div=0 -> constant 0.
4. Load on the exact terminal edge (ch0 div=3, load div=6 when cnt=2) -> new period takes effect at that edge (next toggle 6 edges later), pending[0] never asserts. Two loads (7 then 9) before a boundary -> 9 is applied.
5. Enable drop mid-period (ch3 div=8, clk_out=1) -> clk_out[3]=0 next edge; re-enable -> first rise 8 edges later with rise_tick.
6. Assert reset low mid-count with pending set on all channels -> all outputs 0 asynchronously; after release with enable=1 and no loads, channels toggle every 113636 clocks (DEFAULT_DIV).
